station_cntrl: RTL and testbench



---
 rtl/station_pkg.sv | 11 +
 rtl/buzz_gen.sv | 32 +++
 rtl/station_cntrl.sv | 74 +++++++
 tb/tb_station_cntrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/station_pkg.sv
// Shared opcodes, field positions and FSM state type for the station controller.
package station_pkg;
    localparam logic [1:0] CMD_STOP = 2'b00;
    localparam logic [1:0] CMD_GO   = 2'b01;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 6;
    localparam int DEST_W  = 6;

    typedef enum logic [0:0] {IDLE, MOVING} station_state_t;
endpackage

// File: rtl/buzz_gen.sv
// Piezo square-wave generator: toggles every BUZZ_HALF enabled cycles, silent when disabled.
module buzz_gen #(
    parameter int BUZZ_HALF = 12500
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic buzz,
    output logic buzz_n
);
    localparam int CNT_W = $clog2(BUZZ_HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUZZ_HALF - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            buzz <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            buzz <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            buzz <= ~buzz;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

    assign buzz_n = ~buzz;
endmodule

// File: rtl/station_cntrl.sv
// Station controller: runs from a GO command until the destination barcode is read or STOP arrives.
module station_cntrl
    import station_pkg::*;
#(
    parameter int BUZZ_HALF = 12500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    output logic       clr_cmd_rdy,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    input  logic       OK2Move,
    output logic       go,
    output logic       in_transit,
    output logic       buzz,
    output logic       buzz_n
);
    station_state_t    state;
    logic [DEST_W-1:0] dest;
    logic [1:0]        opc;
    logic              id_hit;
    logic              buzz_en;
    logic              unused_id_hi;

    assign opc    = cmd[OPC_MSB:OPC_LSB];
    assign id_hit = (ID[DEST_W-1:0] == dest);
    // Upstream only validates IDs with zero upper bits, so they never take part in the match.
    assign unused_id_hi = ^ID[OPC_MSB:OPC_LSB];

    // A pending command always wins; an ID waits until no command is presented.
    always_comb begin
        clr_cmd_rdy = 1'b0;
        clr_ID_vld  = 1'b0;
        if (!rst) begin
            if (cmd_rdy)
                clr_cmd_rdy = 1'b1;
            else if (ID_vld)
                clr_ID_vld = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dest  <= '0;
        end else if (cmd_rdy) begin
            if (opc == CMD_GO) begin
                dest  <= cmd[DEST_W-1:0];
                state <= MOVING;
            end else if (opc == CMD_STOP) begin
                state <= IDLE;
            end
        end else if (ID_vld && (state == MOVING) && id_hit) begin
            state <= IDLE;
        end
    end

    assign in_transit = (state == MOVING);
    assign go         = in_transit & OK2Move;
    assign buzz_en    = in_transit & ~OK2Move;

    buzz_gen #(
        .BUZZ_HALF(BUZZ_HALF)
    ) u_buzz (
        .clk   (clk),
        .rst   (rst),
        .en    (buzz_en),
        .buzz  (buzz),
        .buzz_n(buzz_n)
    );
endmodule

// File: tb/tb_station_cntrl.sv
// Directed plus randomized bench for station_cntrl with a cycle-level behavioural reference model.
module tb_station_cntrl;
    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cmd;
    logic       cmd_rdy;
    logic       clr_cmd_rdy;
    logic [7:0] ID;
    logic       ID_vld;
    logic       clr_ID_vld;
    logic       OK2Move;
    logic       go;
    logic       in_transit;
    logic       buzz;
    logic       buzz_n;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_moving;
    int m_dest;
    int m_active;

    station_cntrl #(.BUZZ_HALF(BH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .ID         (ID),
        .ID_vld     (ID_vld),
        .clr_ID_vld (clr_ID_vld),
        .OK2Move    (OK2Move),
        .go         (go),
        .in_transit (in_transit),
        .buzz       (buzz),
        .buzz_n     (buzz_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge, advance the model, play the upstream producers.
    task automatic cycle();
        logic e_clr_cmd, e_clr_id, e_buzz, act;
        #4;
        e_clr_cmd = cmd_rdy & ~rst;
        e_clr_id  = ID_vld & ~cmd_rdy & ~rst;
        e_buzz    = ((m_active / BH) % 2) == 1;
        chk("clr_cmd_rdy", clr_cmd_rdy, e_clr_cmd);
        chk("clr_ID_vld",  clr_ID_vld,  e_clr_id);
        chk("in_transit",  in_transit,  m_moving);
        chk("go",          go,          m_moving & OK2Move);
        chk("buzz",        buzz,        e_buzz);
        chk("buzz_n",      buzz_n,      ~e_buzz);
        if (rst) begin
            m_moving = 0;
            m_dest   = 0;
            m_active = 0;
        end else begin
            act      = m_moving && !OK2Move;
            m_active = act ? m_active + 1 : 0;
            if (cmd_rdy) begin
                if (cmd[7:6] == 2'b01) begin
                    m_moving = 1;
                    m_dest   = int'(cmd[5:0]);
                end else if (cmd[7:6] == 2'b00) begin
                    m_moving = 0;
                end
            end else if (ID_vld && m_moving && int'(ID[5:0]) == m_dest) begin
                m_moving = 0;
            end
        end
        @(posedge clk);
        #1;
        if (e_clr_cmd) cmd_rdy = 1'b0;
        if (e_clr_id)  ID_vld  = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        cmd     = c;
        cmd_rdy = 1'b1;
        for (int i = 0; i < 4 && cmd_rdy; i++) cycle();
    endtask

    task automatic send_id(input logic [7:0] v);
        ID     = v;
        ID_vld = 1'b1;
        for (int i = 0; i < 4 && ID_vld; i++) cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; cmd = 8'h00; cmd_rdy = 1'b0; ID = 8'h00; ID_vld = 1'b0; OK2Move = 1'b1;
        m_moving = 0; m_dest = 0; m_active = 0;
        @(posedge clk);
        #1;
        idle(1);
        rst = 1'b0;
        idle(2);

        // GO to station 5, wrong ID, then matching ID
        send_cmd(8'h45);
        idle(1);
        send_id(8'h03);
        idle(1);
        send_id(8'h05);
        idle(2);

        // STOP and ID presented together while moving
        send_cmd(8'h45);
        cmd = 8'h00; cmd_rdy = 1'b1; ID = 8'h05; ID_vld = 1'b1;
        idle(4);

        // Obstacle: buzzer runs, then clears when path opens
        send_cmd(8'h45);
        OK2Move = 1'b0;
        idle(20);
        OK2Move = 1'b1;
        idle(2);

        // Re-target from 5 to 10
        send_cmd(8'h4A);
        send_id(8'h05);
        idle(1);
        send_id(8'h0A);
        idle(2);

        // Reset mid-transit with buzzer active and inputs pending
        send_cmd(8'h45);
        OK2Move = 1'b0;
        idle(6);
        rst = 1'b1; ID = 8'h07; ID_vld = 1'b1;
        idle(1);
        rst = 1'b0; OK2Move = 1'b1;
        idle(3);

        // Reserved opcode in IDLE
        send_cmd(8'hC7);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (!cmd_rdy && ($urandom % 6 == 0)) begin
                cmd     = {2'($urandom), 3'b000, 3'($urandom)};
                cmd_rdy = 1'b1;
            end
            if (!ID_vld && ($urandom % 3 == 0)) begin
                ID     = {2'($urandom), 3'b000, 3'($urandom)};
                ID_vld = 1'b1;
            end
            OK2Move = ($urandom % 4) != 0;
            rst     = ($urandom % 150) == 0;
            cycle();
        end
        rst = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
